// File: rtl/operand_entry_pkg.sv
// Shared key codes, entry-state and operation encodings for the calculator front end.
// The calculator core imports these unchanged.
package operand_entry_pkg;

  localparam logic [4:0] K_ADD       = 5'd10;
  localparam logic [4:0] K_SUB       = 5'd11;
  localparam logic [4:0] K_XOR       = 5'd12;
  localparam logic [4:0] K_AND       = 5'd13;
  localparam logic [4:0] K_OR        = 5'd14;
  localparam logic [4:0] K_EQUALS    = 5'd15;
  localparam logic [4:0] K_CLEAR     = 5'd16;
  localparam logic [4:0] K_BACKSPACE = 5'd17;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    S_WA  = 2'd0,
    S_WB  = 2'd1,
    S_OBL = 2'd2
  } st_t;

  typedef enum logic [2:0] {
    SL_ADD  = 3'd0,
    SL_SUB  = 3'd1,
    SL_XOR  = 3'd2,
    SL_AND  = 3'd3,
    SL_OR   = 3'd4,
    SL_NONE = 3'd7
  } stl_t;

  typedef enum logic [2:0] {
    SH_HOLD     = 3'd0,
    SH_LOAD     = 3'd1,
    SH_SHR      = 3'd2,
    SH_CLR      = 3'd3,
    SH_CLR_LOAD = 3'd4
  } shift_op_t;

  typedef enum logic [2:0] {
    KC_DIGIT     = 3'd0,
    KC_OP        = 3'd1,
    KC_EQUALS    = 3'd2,
    KC_CLEAR     = 3'd3,
    KC_BACKSPACE = 3'd4,
    KC_UNDEF     = 3'd5
  } key_class_t;

  function automatic key_class_t classify(input logic [4:0] code);
    if (code <= 5'd9)                      return KC_DIGIT;
    else if (code >= K_ADD && code <= K_OR) return KC_OP;
    else if (code == K_EQUALS)              return KC_EQUALS;
    else if (code == K_CLEAR)               return KC_CLEAR;
    else if (code == K_BACKSPACE)           return KC_BACKSPACE;
    else                                    return KC_UNDEF;
  endfunction

  function automatic stl_t op_of(input logic [4:0] code);
    case (code)
      K_ADD:   return SL_ADD;
      K_SUB:   return SL_SUB;
      K_XOR:   return SL_XOR;
      K_AND:   return SL_AND;
      K_OR:    return SL_OR;
      default: return SL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Key-input handshake plus the registered operand/state display bus.
interface operand_entry_if;
  import operand_entry_pkg::*;

  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic [3:0] A1, A2, A3, A4;
  logic [3:0] B1, B2, B3, B4;
  st_t        ST;
  stl_t       ST_L;
  logic       err;

  modport master (
    output key_valid, key_code,
    input  key_ready, A1, A2, A3, A4, B1, B2, B3, B4, ST, ST_L, err
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, A1, A2, A3, A4, B1, B2, B3, B4, ST, ST_L, err
  );

endinterface

// File: rtl/operand_entry_bcd_shift4.sv
// bcd_shift4: 4-digit BCD register with digit count; load-left inserts at the ones digit,
// shift-right drops the ones digit, clear zeroes everything.
module bcd_shift4
  import operand_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  shift_op_t   i_op,
  input  logic [3:0]  i_digit,
  output logic [15:0] o_digits,
  output logic [2:0]  o_count
);

  logic [15:0] r_digits, w_digits_next;
  logic [2:0]  r_count, w_count_next;

  // Range checks on the count are the caller's job; this block just applies the op.
  always_comb begin
    w_digits_next = r_digits;
    w_count_next  = r_count;
    case (i_op)
      SH_LOAD: begin
        w_digits_next = {r_digits[11:0], i_digit};
        w_count_next  = r_count + 3'd1;
      end
      SH_SHR: begin
        w_digits_next = {4'd0, r_digits[15:4]};
        w_count_next  = r_count - 3'd1;
      end
      SH_CLR: begin
        w_digits_next = 16'd0;
        w_count_next  = 3'd0;
      end
      SH_CLR_LOAD: begin
        w_digits_next = {12'd0, i_digit};
        w_count_next  = 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= 16'd0;
      r_count  <= 3'd0;
    end else begin
      r_digits <= w_digits_next;
      r_count  <= w_count_next;
    end
  end

  assign o_digits = r_digits;
  assign o_count  = r_count;

endmodule

// File: rtl/operand_entry.sv
// Calculator operand entry: collects two 4-digit BCD operands and an operator from key events.
// Define OPERAND_ENTRY_BACKSPACE_EN to enable the backspace key (code 17).
module operand_entry
  import operand_entry_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  operand_entry_if.slave bus
);

  st_t        r_st, w_st_next;
  stl_t       r_stl, w_stl_next;
  logic       r_err, w_err_next;
  logic       r_ready;
  logic       w_accept;
  key_class_t w_class;
  shift_op_t  w_a_op, w_b_op;
  logic [15:0] w_a_digits, w_b_digits;
  logic [2:0]  w_a_count, w_b_count;

  assign w_accept = bus.key_valid & r_ready;
  assign w_class  = classify(bus.key_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= S_WA;
      r_stl   <= SL_NONE;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_st    <= w_st_next;
      r_stl   <= w_stl_next;
      r_err   <= w_err_next;
      // One dead cycle after every accepted key.
      r_ready <= ~w_accept;
    end
  end

  always_comb begin
    w_st_next  = r_st;
    w_stl_next = r_stl;
    w_err_next = 1'b0;
    w_a_op     = SH_HOLD;
    w_b_op     = SH_HOLD;
    if (w_accept) begin
      case (w_class)
        KC_DIGIT: begin
          case (r_st)
            S_WA: begin
              if (w_a_count < MAX_DIGITS) w_a_op = SH_LOAD;
              else                        w_err_next = 1'b1;
            end
            S_WB: begin
              if (w_b_count < MAX_DIGITS) w_b_op = SH_LOAD;
              else                        w_err_next = 1'b1;
            end
            default: begin
              // A digit after a result starts a fresh calculation.
              w_a_op     = SH_CLR_LOAD;
              w_b_op     = SH_CLR;
              w_stl_next = SL_NONE;
              w_st_next  = S_WA;
            end
          endcase
        end
        KC_OP: begin
          case (r_st)
            S_WA: begin
              w_stl_next = op_of(bus.key_code);
              w_st_next  = S_WB;
              w_b_op     = SH_CLR;
            end
            S_WB: begin
              if (w_b_count == 3'd0) w_stl_next = op_of(bus.key_code);
              else                   w_err_next = 1'b1;
            end
            default: w_err_next = 1'b1;
          endcase
        end
        KC_EQUALS: begin
          if (r_st == S_WB) w_st_next  = S_OBL;
          else              w_err_next = 1'b1;
        end
        KC_CLEAR: begin
          w_a_op     = SH_CLR;
          w_b_op     = SH_CLR;
          w_st_next  = S_WA;
          w_stl_next = SL_NONE;
        end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        KC_BACKSPACE: begin
          if (r_st == S_WA && w_a_count != 3'd0)      w_a_op = SH_SHR;
          else if (r_st == S_WB && w_b_count != 3'd0) w_b_op = SH_SHR;
          else                                        w_err_next = 1'b1;
        end
`endif
        default: w_err_next = 1'b1;
      endcase
    end
  end

  bcd_shift4 u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_op     (w_a_op),
    .i_digit  (bus.key_code[3:0]),
    .o_digits (w_a_digits),
    .o_count  (w_a_count)
  );

  bcd_shift4 u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_op     (w_b_op),
    .i_digit  (bus.key_code[3:0]),
    .o_digits (w_b_digits),
    .o_count  (w_b_count)
  );

  assign bus.key_ready = r_ready;
  assign bus.err       = r_err;
  assign bus.ST        = r_st;
  assign bus.ST_L      = r_stl;
  assign bus.A1        = w_a_digits[15:12];
  assign bus.A2        = w_a_digits[11:8];
  assign bus.A3        = w_a_digits[7:4];
  assign bus.A4        = w_a_digits[3:0];
  assign bus.B1        = w_b_digits[15:12];
  assign bus.B2        = w_b_digits[11:8];
  assign bus.B3        = w_b_digits[7:4];
  assign bus.B4        = w_b_digits[3:0];

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: key sequences with hand-computed operand/state results.
module tb_operand_entry;
  import operand_entry_pkg::*;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  operand_entry_if bus();

  operand_entry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] a_val();
    return {bus.A1, bus.A2, bus.A3, bus.A4};
  endfunction

  function automatic logic [15:0] b_val();
    return {bus.B1, bus.B2, bus.B3, bus.B4};
  endfunction

  task automatic do_reset();
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for ready, presents one key for one edge, returns err seen after that edge.
  task automatic press(input logic [4:0] code, output logic err_o);
    int n;
    n = 0;
    while (bus.key_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL ready_timeout key=%0d", code);
    end
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk); #1;
    err_o = bus.err;
    bus.key_valid = 1'b0;
    $display("key %0d -> A=%h B=%h ST=%0d ST_L=%0d err=%b", code, a_val(), b_val(), bus.ST, bus.ST_L, err_o);
  endtask

  task automatic test_reset();
    logic e;
    do_reset();
    press(5'd1, e); press(K_ADD, e); press(5'd2, e);
    rst_n = 1'b0;
    #1;
    compared++; if (a_val() !== 16'h0000) begin mismatched++; $display("FAIL reset_A got %h exp 0000", a_val()); end
    compared++; if (b_val() !== 16'h0000) begin mismatched++; $display("FAIL reset_B got %h exp 0000", b_val()); end
    compared++; if (bus.ST !== S_WA) begin mismatched++; $display("FAIL reset_ST got %0d exp %0d", bus.ST, S_WA); end
    compared++; if (bus.ST_L !== SL_NONE) begin mismatched++; $display("FAIL reset_STL got %0d exp %0d", bus.ST_L, SL_NONE); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b exp 0", bus.err); end
    compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b exp 1", bus.key_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic e; logic any;
    do_reset();
    any = 1'b0;
    press(5'd1, e); any |= e; press(5'd2, e); any |= e; press(5'd3, e); any |= e;
    press(K_ADD, e); any |= e;
    press(5'd4, e); any |= e; press(5'd5, e); any |= e;
    press(K_EQUALS, e); any |= e;
    compared++; if (a_val() !== 16'h0123) begin mismatched++; $display("FAIL basic_A got %h exp 0123", a_val()); end
    compared++; if (b_val() !== 16'h0045) begin mismatched++; $display("FAIL basic_B got %h exp 0045", b_val()); end
    compared++; if (bus.ST_L !== SL_ADD) begin mismatched++; $display("FAIL basic_STL got %0d exp %0d", bus.ST_L, SL_ADD); end
    compared++; if (bus.ST !== S_OBL) begin mismatched++; $display("FAIL basic_ST got %0d exp %0d", bus.ST, S_OBL); end
    compared++; if (any !== 1'b0) begin mismatched++; $display("FAIL basic_err got %b exp 0", any); end
    // Keys rejected in S_OBL must not disturb the result.
    press(K_EQUALS, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL obl_equals_err got %b exp 1", e); end
    press(K_SUB, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL obl_op_err got %b exp 1", e); end
    compared++; if ({a_val(), b_val()} !== 32'h0123_0045) begin mismatched++; $display("FAIL obl_hold got %h exp 01230045", {a_val(), b_val()}); end
    compared++; if (bus.ST_L !== SL_ADD) begin mismatched++; $display("FAIL obl_hold_STL got %0d exp %0d", bus.ST_L, SL_ADD); end
  endtask

  task automatic test_overflow();
    logic e; logic any;
    do_reset();
    any = 1'b0;
    repeat (4) begin press(5'd9, e); any |= e; end
    compared++; if (any !== 1'b0) begin mismatched++; $display("FAIL ovf_early_err got %b exp 0", any); end
    press(5'd7, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL ovf_err got %b exp 1", e); end
    compared++; if (a_val() !== 16'h9999) begin mismatched++; $display("FAIL ovf_A got %h exp 9999", a_val()); end
    press(5'd7, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL ovf_err2 got %b exp 1", e); end
    @(posedge clk); #1;
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("FAIL err_pulse_width got %b exp 0", bus.err); end
  endtask

  task automatic test_operator();
    logic e;
    do_reset();
    press(5'd5, e); press(K_ADD, e);
    press(K_SUB, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL op_replace_err got %b exp 0", e); end
    press(5'd6, e);
    press(K_XOR, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL op_xor_err got %b exp 1", e); end
    compared++; if (bus.ST_L !== SL_SUB) begin mismatched++; $display("FAIL op_STL got %0d exp %0d", bus.ST_L, SL_SUB); end
    compared++; if (b_val() !== 16'h0006) begin mismatched++; $display("FAIL op_B got %h exp 0006", b_val()); end
    compared++; if (a_val() !== 16'h0005) begin mismatched++; $display("FAIL op_A got %h exp 0005", a_val()); end
  endtask

  task automatic test_obl_digit();
    logic e;
    do_reset();
    press(5'd1, e); press(5'd2, e); press(K_OR, e); press(5'd3, e); press(K_EQUALS, e);
    press(5'd8, e);
    compared++; if (a_val() !== 16'h0008) begin mismatched++; $display("FAIL obl_A got %h exp 0008", a_val()); end
    compared++; if (b_val() !== 16'h0000) begin mismatched++; $display("FAIL obl_B got %h exp 0000", b_val()); end
    compared++; if (bus.ST_L !== SL_NONE) begin mismatched++; $display("FAIL obl_STL got %0d exp %0d", bus.ST_L, SL_NONE); end
    compared++; if (bus.ST !== S_WA) begin mismatched++; $display("FAIL obl_ST got %0d exp %0d", bus.ST, S_WA); end
    // A count restarted at 1: three more digits fit, the fourth is rejected.
    press(5'd1, e); press(5'd2, e); press(5'd3, e);
    compared++; if (a_val() !== 16'h8123) begin mismatched++; $display("FAIL obl_count_A got %h exp 8123", a_val()); end
    press(5'd4, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL obl_count_err got %b exp 1", e); end
    press(K_EQUALS, e);
    compared++; if (e !== 1'b1 || bus.ST !== S_WA) begin mismatched++; $display("FAIL wa_equals got err=%b ST=%0d exp err=1 ST=0", e, bus.ST); end
  endtask

  task automatic test_back_to_back();
    int acc; logic any;
    do_reset();
    acc = 0; any = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd1;
    for (int i = 0; i < 6; i++) begin
      if (bus.key_ready === 1'b1) acc++;
      @(posedge clk); #1;
      any |= bus.err;
    end
    bus.key_valid = 1'b0;
    $display("hold key 1 x6 -> accepts=%0d A=%h", acc, a_val());
    compared++; if (acc !== 3) begin mismatched++; $display("FAIL b2b_accepts got %0d exp 3", acc); end
    compared++; if (a_val() !== 16'h0111) begin mismatched++; $display("FAIL b2b_A got %h exp 0111", a_val()); end
    compared++; if (any !== 1'b0) begin mismatched++; $display("FAIL b2b_err got %b exp 0", any); end
  endtask

  task automatic test_clear_undef();
    logic e;
    do_reset();
    press(5'd1, e); press(K_AND, e); press(5'd2, e);
    press(5'd20, e);
    compared++; if (e !== 1'b1 || b_val() !== 16'h0002) begin mismatched++; $display("FAIL undef got err=%b B=%h exp err=1 B=0002", e, b_val()); end
    press(K_CLEAR, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL clear_err got %b exp 0", e); end
    compared++; if ({a_val(), b_val()} !== 32'h0) begin mismatched++; $display("FAIL clear_AB got %h exp 00000000", {a_val(), b_val()}); end
    compared++; if (bus.ST !== S_WA || bus.ST_L !== SL_NONE) begin mismatched++; $display("FAIL clear_state got ST=%0d ST_L=%0d exp 0/7", bus.ST, bus.ST_L); end
  endtask

  task automatic test_backspace();
    logic e;
    do_reset();
    press(5'd4, e); press(5'd7, e);
    press(K_BACKSPACE, e);
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    compared++; if (a_val() !== 16'h0004 || e !== 1'b0) begin mismatched++; $display("FAIL bs_A got A=%h err=%b exp A=0004 err=0", a_val(), e); end
    press(K_BACKSPACE, e);
    press(K_BACKSPACE, e);
    compared++; if (a_val() !== 16'h0000 || e !== 1'b1) begin mismatched++; $display("FAIL bs_empty got A=%h err=%b exp A=0000 err=1", a_val(), e); end
`else
    compared++; if (a_val() !== 16'h0047 || e !== 1'b1) begin mismatched++; $display("FAIL bs_disabled got A=%h err=%b exp A=0047 err=1", a_val(), e); end
`endif
  endtask

  task automatic test_mid_reset();
    logic e;
    do_reset();
    press(5'd3, e); press(5'd4, e); press(K_XOR, e); press(5'd2, e);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    compared++; if ({a_val(), b_val()} !== 32'h0 || bus.ST !== S_WA) begin mismatched++; $display("FAIL midrst got AB=%h ST=%0d exp 0/0", {a_val(), b_val()}, bus.ST); end
    press(5'd5, e);
    compared++; if (a_val() !== 16'h0005 || bus.ST_L !== SL_NONE) begin mismatched++; $display("FAIL midrst_first got A=%h ST_L=%0d exp 0005/7", a_val(), bus.ST_L); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_operator();
    test_obl_digit();
    test_back_to_back();
    test_clear_undef();
    test_backspace();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
